// File: rtl/ccip_c0_req_mux.sv
// rtl/ccip_c0_req_mux.sv - round-robin N-port mux for the CCI-P c0 read channel
//
// Purpose: arbitrates per-port read requests onto one c0 Tx stream, stamps the
// port ID into the mdata MSBs, and steers c0 Rx responses back to the issuing
// port using those bits. Each port has an outstanding-read credit limit.
//
// Ports:
//   pClk, pReset_n                  clock, async-assert active-low reset
//   req_valid/req_ready             per-port request handshake (ready is combinational)
//   req_addr, req_mdata             per-port request payload, port i in slice i
//   c0_tx_valid/addr/mdata          registered request toward CCI-P
//   c0_tx_almfull                   CCI-P almost-full, blocks all grants
//   c0_rx_valid/mdata/data          read responses from CCI-P
//   rsp_valid/mdata/data            registered, one-hot-steered responses
//   outstanding                     per-port in-flight read count
//   err_bad_port                    sticky: bad response port ID or counter underflow
module ccip_c0_req_mux #(
    parameter int N_PORTS         = 4,
    parameter int ADDR_W          = 42,
    parameter int MDATA_W         = 16,
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 32,
    parameter int PID_W           = $clog2(N_PORTS),
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       pClk,
    input  logic                       pReset_n,
    input  logic [N_PORTS-1:0]         req_valid,
    output logic [N_PORTS-1:0]         req_ready,
    input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
    input  logic [N_PORTS*MDATA_W-1:0] req_mdata,
    output logic                       c0_tx_valid,
    output logic [ADDR_W-1:0]          c0_tx_addr,
    output logic [MDATA_W-1:0]         c0_tx_mdata,
    input  logic                       c0_tx_almfull,
    input  logic                       c0_rx_valid,
    input  logic [MDATA_W-1:0]         c0_rx_mdata,
    input  logic [DATA_W-1:0]          c0_rx_data,
    output logic [N_PORTS-1:0]         rsp_valid,
    output logic [MDATA_W-1:0]         rsp_mdata,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [N_PORTS*CNT_W-1:0]   outstanding,
    output logic                       err_bad_port
);

    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PID_W:0]   NPORT_CNT = (PID_W + 1)'(N_PORTS);

    logic [PID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0]  tx_addr_q, tx_addr_d;
    logic [MDATA_W-1:0] tx_mdata_q, tx_mdata_d;
    logic [N_PORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [MDATA_W-1:0] rsp_mdata_q, rsp_mdata_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q [N_PORTS];
    logic [CNT_W-1:0]   cnt_d [N_PORTS];

    logic [ADDR_W-1:0]  addr_arr  [N_PORTS];
    logic [MDATA_W-1:0] mdata_arr [N_PORTS];
    logic [N_PORTS-1:0] eligible;
    logic               grant_vld;
    logic [PID_W-1:0]   grant_idx;
    logic [PID_W-1:0]   rx_pid;
    logic               rx_pid_ok;
    logic               rx_hit;
    logic               underflow;

    // (base + k) mod N_PORTS without relying on N_PORTS being a power of two
    function automatic logic [PID_W-1:0] wrap_idx(input logic [PID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_PORTS) s = s - N_PORTS;
        return PID_W'(s);
    endfunction

    // Port-ID bits of each request's mdata are overwritten on issue
    logic unused_mdata_top;
    assign unused_mdata_top = ^req_mdata;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            mdata_arr[i] = req_mdata[i*MDATA_W +: MDATA_W];
            // Reset gating keeps req_ready low while pReset_n is asserted
            eligible[i]  = pReset_n & req_valid[i] & ~c0_tx_almfull & (cnt_q[i] < MAX_CNT);
        end
    end

    // Round-robin: first eligible port at or after rr_ptr
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!grant_vld && eligible[wrap_idx(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(rr_ptr_q, k);
            end
        end
        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        rx_pid    = c0_rx_mdata[MDATA_W-1 -: PID_W];
        rx_pid_ok = ({1'b0, rx_pid} < NPORT_CNT);
        rx_hit    = c0_rx_valid & rx_pid_ok;

        rr_ptr_d   = grant_vld ? wrap_idx(grant_idx, 1) : rr_ptr_q;
        tx_valid_d = grant_vld;
        tx_addr_d  = tx_addr_q;
        tx_mdata_d = tx_mdata_q;
        if (grant_vld) begin
            tx_addr_d  = addr_arr[grant_idx];
            tx_mdata_d = {grant_idx, mdata_arr[grant_idx][MDATA_W-PID_W-1:0]};
        end

        rsp_valid_d = '0;
        if (rx_hit) rsp_valid_d[rx_pid] = 1'b1;
        rsp_mdata_d = rsp_mdata_q;
        rsp_data_d  = rsp_data_q;
        if (c0_rx_valid) begin
            rsp_mdata_d = {{PID_W{1'b0}}, c0_rx_mdata[MDATA_W-PID_W-1:0]};
            rsp_data_d  = c0_rx_data;
        end

        // Simultaneous accept and response for a port cancel out
        underflow = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            logic inc, dec;
            inc = grant_vld && (grant_idx == PID_W'(i));
            dec = rx_hit && (rx_pid == PID_W'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) underflow = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        err_d = err_q | (c0_rx_valid & ~rx_pid_ok) | underflow;
    end

    always_ff @(posedge pClk or negedge pReset_n) begin
        if (!pReset_n) begin
            rr_ptr_q    <= '0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            rsp_valid_q <= '0;
            rsp_mdata_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tx_valid_q  <= tx_valid_d;
            tx_addr_q   <= tx_addr_d;
            tx_mdata_q  <= tx_mdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_mdata_q <= rsp_mdata_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign c0_tx_valid  = tx_valid_q;
    assign c0_tx_addr   = tx_addr_q;
    assign c0_tx_mdata  = tx_mdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_mdata    = rsp_mdata_q;
    assign rsp_data     = rsp_data_q;
    assign err_bad_port = err_q;

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < N_PORTS; i++) outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
    end

endmodule

// File: tb/tb_ccip_c0_req_mux.sv
// tb/tb_ccip_c0_req_mux.sv - directed self-checking bench for ccip_c0_req_mux
module tb_ccip_c0_req_mux;

    logic pClk = 1'b0;
    logic pReset_n = 1'b0;
    always #5 pClk = ~pClk;

    // Main instance: 4 ports, credit limit 2 (CNT_W = 2)
    logic [3:0]    req_valid, req_ready;
    logic [167:0]  req_addr;
    logic [63:0]   req_mdata;
    logic          c0_tx_valid, c0_tx_almfull, c0_rx_valid, err_bad_port;
    logic [41:0]   c0_tx_addr;
    logic [15:0]   c0_tx_mdata, c0_rx_mdata, rsp_mdata;
    logic [63:0]   c0_rx_data, rsp_data;
    logic [3:0]    rsp_valid;
    logic [7:0]    outstanding;

    ccip_c0_req_mux #(.N_PORTS(4), .ADDR_W(42), .MDATA_W(16), .DATA_W(64), .MAX_OUTSTANDING(2)) u_dut (
        .pClk(pClk), .pReset_n(pReset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_mdata(req_mdata),
        .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata),
        .c0_tx_almfull(c0_tx_almfull),
        .c0_rx_valid(c0_rx_valid), .c0_rx_mdata(c0_rx_mdata), .c0_rx_data(c0_rx_data),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
        .outstanding(outstanding), .err_bad_port(err_bad_port)
    );

    // Second instance: 3 ports, so port ID 3 is out of range (CNT_W = 6)
    logic [2:0]    b_req_valid, b_req_ready, b_rsp_valid;
    logic [125:0]  b_req_addr;
    logic [47:0]   b_req_mdata;
    logic          b_tx_valid, b_rx_valid, b_err;
    logic [41:0]   b_tx_addr;
    logic [15:0]   b_tx_mdata, b_rx_mdata, b_rsp_mdata;
    logic [63:0]   b_rx_data, b_rsp_data;
    logic [17:0]   b_outstanding;

    ccip_c0_req_mux #(.N_PORTS(3), .ADDR_W(42), .MDATA_W(16), .DATA_W(64), .MAX_OUTSTANDING(32)) u_dut3 (
        .pClk(pClk), .pReset_n(pReset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr), .req_mdata(b_req_mdata),
        .c0_tx_valid(b_tx_valid), .c0_tx_addr(b_tx_addr), .c0_tx_mdata(b_tx_mdata),
        .c0_tx_almfull(1'b0),
        .c0_rx_valid(b_rx_valid), .c0_rx_mdata(b_rx_mdata), .c0_rx_data(b_rx_data),
        .rsp_valid(b_rsp_valid), .rsp_mdata(b_rsp_mdata), .rsp_data(b_rsp_data),
        .outstanding(b_outstanding), .err_bad_port(b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0; c0_tx_almfull = 1'b0; c0_rx_valid = 1'b0; b_rx_valid = 1'b0;
        pReset_n = 1'b0;
        tick();
        pReset_n = 1'b1;
    endtask

    task automatic test_reset();
        pReset_n = 1'b0;
        req_valid = 4'hF;
        @(negedge pClk);
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_ready got %h want 0", req_ready); end
        n_cmp++; if (c0_tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got %b want 0", c0_tx_valid); end
        n_cmp++; if (rsp_valid !== 4'h0) begin n_bad++; $display("FAIL reset_rsp_valid got %h want 0", rsp_valid); end
        n_cmp++; if (outstanding !== 8'h00) begin n_bad++; $display("FAIL reset_outstanding got %h want 0", outstanding); end
        n_cmp++; if (err_bad_port !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_bad_port); end
        req_valid = '0;
        tick();
        pReset_n = 1'b1;
    endtask

    task automatic test_single_port();
        do_reset();
        req_addr[2*42 +: 42] = 42'h100;
        req_mdata[2*16 +: 16] = 16'h0055;
        req_valid = 4'b0100;
        @(negedge pClk);
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        @(negedge pClk);
        n_cmp++; if (c0_tx_valid !== 1'b1) begin n_bad++; $display("FAIL single_tx_valid got %b want 1", c0_tx_valid); end
        n_cmp++; if (c0_tx_addr !== 42'h100) begin n_bad++; $display("FAIL single_tx_addr got %h want 100", c0_tx_addr); end
        n_cmp++; if (c0_tx_mdata !== 16'h8055) begin n_bad++; $display("FAIL single_tx_mdata got %h want 8055", c0_tx_mdata); end
        n_cmp++; if (outstanding !== 8'h10) begin n_bad++; $display("FAIL single_outstanding got %h want 10", outstanding); end
        tick();
        @(negedge pClk);
        n_cmp++; if (c0_tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_tx_drain got %b want 0", c0_tx_valid); end
        c0_rx_valid = 1'b1; c0_rx_mdata = 16'h8055; c0_rx_data = 64'hDEAD_BEEF_0123_4567;
        tick();
        c0_rx_valid = 1'b0;
        @(negedge pClk);
        n_cmp++; if (rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL single_rsp_valid got %b want 0100", rsp_valid); end
        n_cmp++; if (rsp_mdata !== 16'h0055) begin n_bad++; $display("FAIL single_rsp_mdata got %h want 0055", rsp_mdata); end
        n_cmp++; if (rsp_data !== 64'hDEAD_BEEF_0123_4567) begin n_bad++; $display("FAIL single_rsp_data got %h want deadbeef01234567", rsp_data); end
        n_cmp++; if (outstanding !== 8'h00) begin n_bad++; $display("FAIL single_outstanding_ret got %h want 0", outstanding); end
        tick();
        @(negedge pClk);
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_rsp_pulse got %b want 0", rsp_valid); end
    endtask

    task automatic test_fairness();
        logic [15:0] exp_md;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            req_addr[p*42 +: 42] = 42'h1000 + 42'(p);
            req_mdata[p*16 +: 16] = 16'hC010 + 16'(p);
        end
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(negedge pClk);
            n_cmp++; if (req_ready !== (4'b0001 << (c % 4))) begin n_bad++; $display("FAIL fair_grant%0d got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
            if (c > 0) begin
                exp_md = (16'((c - 1) % 4) << 14) | (16'h0010 + 16'((c - 1) % 4));
                n_cmp++; if (c0_tx_mdata !== exp_md) begin n_bad++; $display("FAIL fair_mdata%0d got %h want %h", c, c0_tx_mdata, exp_md); end
            end
            tick();
        end
        @(negedge pClk);
        n_cmp++; if (outstanding !== 8'hAA) begin n_bad++; $display("FAIL fair_outstanding got %h want aa", outstanding); end
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL fair_all_capped got %b want 0", req_ready); end
        n_cmp++; if (c0_tx_addr !== 42'h1003) begin n_bad++; $display("FAIL fair_last_addr got %h want 1003", c0_tx_addr); end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'hF;
        @(negedge pClk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_first got %b want 0001", req_ready); end
        tick();
        c0_tx_almfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge pClk);
            n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL bp_ready%0d got %b want 0", c, req_ready); end
            n_cmp++; if (c0_tx_valid !== (c == 0)) begin n_bad++; $display("FAIL bp_tx%0d got %b want %b", c, c0_tx_valid, c == 0); end
            tick();
        end
        c0_tx_almfull = 1'b0;
        @(negedge pClk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_resume got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        @(negedge pClk);
        n_cmp++; if (c0_tx_mdata[15:14] !== 2'd1) begin n_bad++; $display("FAIL bp_resume_pid got %0d want 1", c0_tx_mdata[15:14]); end
    endtask

    task automatic test_credit();
        do_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            @(negedge pClk);
            n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL credit_req%0d got %b want 0001", c, req_ready); end
            tick();
        end
        @(negedge pClk);
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL credit_blocked got %b want 0", req_ready); end
        n_cmp++; if (outstanding[1:0] !== 2'd2) begin n_bad++; $display("FAIL credit_cnt got %0d want 2", outstanding[1:0]); end
        c0_rx_valid = 1'b1; c0_rx_mdata = 16'h0007;
        tick();
        c0_rx_valid = 1'b0;
        @(negedge pClk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL credit_reopen got %b want 0001", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL credit_rsp got %b want 0001", rsp_valid); end
        tick();
        req_valid = '0;
        @(negedge pClk);
        n_cmp++; if (outstanding[1:0] !== 2'd2) begin n_bad++; $display("FAIL credit_third got %0d want 2", outstanding[1:0]); end
        n_cmp++; if (c0_tx_valid !== 1'b1) begin n_bad++; $display("FAIL credit_third_tx got %b want 1", c0_tx_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 4'b0010;
        tick();
        c0_rx_valid = 1'b1; c0_rx_mdata = 16'h4001;
        @(negedge pClk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL simul_ready got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        c0_rx_mdata = 16'hC000;
        @(negedge pClk);
        n_cmp++; if (outstanding !== 8'h04) begin n_bad++; $display("FAIL simul_cnt got %h want 04", outstanding); end
        n_cmp++; if (rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL simul_rsp got %b want 0010", rsp_valid); end
        n_cmp++; if (err_bad_port !== 1'b0) begin n_bad++; $display("FAIL simul_err got %b want 0", err_bad_port); end
        tick();
        c0_rx_valid = 1'b0;
        @(negedge pClk);
        n_cmp++; if (err_bad_port !== 1'b1) begin n_bad++; $display("FAIL underflow_err got %b want 1", err_bad_port); end
        n_cmp++; if (outstanding !== 8'h04) begin n_bad++; $display("FAIL underflow_cnt got %h want 04", outstanding); end
        n_cmp++; if (rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL underflow_rsp got %b want 1000", rsp_valid); end
    endtask

    task automatic test_bad_pid();
        do_reset();
        @(negedge pClk);
        n_cmp++; if (b_err !== 1'b0) begin n_bad++; $display("FAIL badpid_init got %b want 0", b_err); end
        b_rx_valid = 1'b1; b_rx_mdata = 16'hC123;
        tick();
        b_rx_valid = 1'b0;
        @(negedge pClk);
        n_cmp++; if (b_rsp_valid !== 3'b000) begin n_bad++; $display("FAIL badpid_rsp got %b want 000", b_rsp_valid); end
        n_cmp++; if (b_err !== 1'b1) begin n_bad++; $display("FAIL badpid_err got %b want 1", b_err); end
        n_cmp++; if (b_outstanding !== 18'h0) begin n_bad++; $display("FAIL badpid_cnt got %h want 0", b_outstanding); end
        tick(); tick();
        @(negedge pClk);
        n_cmp++; if (b_err !== 1'b1) begin n_bad++; $display("FAIL badpid_sticky got %b want 1", b_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'hF;
        tick(); tick();
        #2;
        pReset_n = 1'b0;
        #1;
        n_cmp++; if (c0_tx_valid !== 1'b0) begin n_bad++; $display("FAIL areset_tx got %b want 0", c0_tx_valid); end
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL areset_ready got %b want 0", req_ready); end
        n_cmp++; if (outstanding !== 8'h00) begin n_bad++; $display("FAIL areset_cnt got %h want 0", outstanding); end
        tick();
        pReset_n = 1'b1;
        @(negedge pClk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL areset_rr got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        c0_rx_valid = 1'b1; c0_rx_mdata = 16'h4002;
        tick();
        c0_rx_valid = 1'b0;
        @(negedge pClk);
        n_cmp++; if (rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL areset_inflight_rsp got %b want 0010", rsp_valid); end
        n_cmp++; if (err_bad_port !== 1'b1) begin n_bad++; $display("FAIL areset_inflight_err got %b want 1", err_bad_port); end
        n_cmp++; if (outstanding !== 8'h01) begin n_bad++; $display("FAIL areset_inflight_cnt got %h want 01", outstanding); end
    endtask

    initial begin
        req_valid = '0; req_addr = '0; req_mdata = '0;
        c0_tx_almfull = 1'b0; c0_rx_valid = 1'b0; c0_rx_mdata = '0; c0_rx_data = '0;
        b_req_valid = '0; b_req_addr = '0; b_req_mdata = '0;
        b_rx_valid = 1'b0; b_rx_mdata = '0; b_rx_data = '0;
        test_reset();
        test_single_port();
        test_fairness();
        test_backpressure();
        test_credit();
        test_simultaneous();
        test_bad_pid();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before test sequence completed");
        $fatal(1);
    end

endmodule
